// File: rtl/sum_frame_packer_pkg.sv
// Shared types and constants for the adder-result frame packer.
// The sample width is common with the upstream adder stage.
package sum_pkg;

    localparam int SUM_W = 3;
    localparam int ACC_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] total;
        logic [SUM_W-1:0] max;
    } frame_t;

    function automatic logic [SUM_W-1:0] max_sum(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sum_frame_packer_if.sv
// Sample input stream plus frame output stream and status of the packer.
// The master modport is the packer side; slave is the consumer/driver side.
interface sum_frame_packer_if #(
    parameter int ACC_W      = 8,
    parameter int FIFO_DEPTH = 4
) ();
    import sum_pkg::*;

    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 in_valid;
    logic [SUM_W-1:0]     in_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_total;
    logic [SUM_W-1:0]     out_max;
    logic                 drop;
    logic [FILL_W-1:0]    fill;

    modport master (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output out_valid,
        output out_total,
        output out_max,
        output drop,
        output fill
    );

    modport slave (
        output in_valid,
        output in_sum,
        output out_ready,
        input  out_valid,
        input  out_total,
        input  out_max,
        input  drop,
        input  fill
    );

endinterface

// File: rtl/sum_frame_packer_sync_fifo.sv
// Single-clock FIFO using extra pointer MSBs to tell full from empty.
// Head is read combinationally so a push is visible on the next cycle.
module sync_fifo
    import sum_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic        do_push;
    logic        do_pop;

    T mem [DEPTH];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A push into a full queue is still legal when the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];
    assign fill  = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/sum_frame_packer.sv
// Accumulates SAMPLES_PER_FRAME valid adder results into {total, max} frames
// and queues them for a valid/ready consumer, flagging lost frames stickily.
module sum_frame_packer
    import sum_pkg::*;
#(
    parameter int SAMPLES_PER_FRAME = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int ACC_W             = sum_pkg::ACC_W
) (
    input logic               clk,
    input logic               rst,
    sum_frame_packer_if.master bus
);
    localparam int CNT_W  = $clog2(SAMPLES_PER_FRAME);
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_FRAME - 1);

    typedef struct packed {
        logic [ACC_W-1:0] total;
        logic [SUM_W-1:0] max;
    } rec_t;

    // Elaboration-time guards on the parameter ranges the datapath relies on.
    if (SAMPLES_PER_FRAME < 2) begin : g_bad_frame
        $error("SAMPLES_PER_FRAME must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (ACC_W < SUM_W + CNT_W) begin : g_bad_acc
        $error("ACC_W too narrow for the largest frame total");
    end

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [SUM_W-1:0]  mx_reg, mx_next;
    logic              drop_reg, drop_next;

    logic [ACC_W-1:0]  sample_ext;
    logic              frame_done;
    logic              pop_eff;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FILL_W-1:0] fifo_fill;
    rec_t              wr_rec;
    rec_t              rd_rec;

    assign sample_ext = ACC_W'(bus.in_sum);

    // The running values always include the current sample; on the last sample
    // they become the frame record and the accumulators restart at zero.
    always_comb begin
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        mx_next      = mx_reg;
        frame_done   = 1'b0;
        wr_rec.total = acc_reg + sample_ext;
        wr_rec.max   = max_sum(mx_reg, bus.in_sum);
        if (bus.in_valid) begin
            if (cnt_reg == CNT_LAST) begin
                frame_done = 1'b1;
                cnt_next   = '0;
                acc_next   = '0;
                mx_next    = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
                acc_next = wr_rec.total;
                mx_next  = wr_rec.max;
            end
        end
    end

    assign pop_eff   = !fifo_empty && bus.out_ready;
    assign drop_next = drop_reg | (frame_done && fifo_full && !pop_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            acc_reg  <= '0;
            mx_reg   <= '0;
            drop_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            acc_reg  <= acc_next;
            mx_reg   <= mx_next;
            drop_reg <= drop_next;
        end
    end

    sync_fifo #(
        .T     (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (frame_done),
        .pop   (bus.out_ready),
        .wdata (wr_rec),
        .rdata (rd_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fifo_fill)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_total = rd_rec.total;
    assign bus.out_max   = rd_rec.max;
    assign bus.drop      = drop_reg;
    assign bus.fill      = fifo_fill;

endmodule

// File: tb/tb_sum_frame_packer.sv
// Directed vector table plus a randomised run against a queue-based model.
module tb_sum_frame_packer;
    import sum_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sum_frame_packer_if #(.ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) bus ();

    sum_frame_packer #(
        .SAMPLES_PER_FRAME (N),
        .FIFO_DEPTH        (DEPTH),
        .ACC_W             (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       do_rst;
        logic       iv;
        logic [2:0] s;
        logic       rdy;
        logic       ev;
        frame_t     ef;
        int         efill;
        logic       ed;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic iv, input int s, input logic rdy,
                                input logic ev, input int t, input int m, input int f,
                                input logic d, input string tag);
        vec_t v;
        v.do_rst   = r;
        v.iv       = iv;
        v.s        = 3'(s);
        v.rdy      = rdy;
        v.ev       = ev;
        v.ef.total = 8'(t);
        v.ef.max   = 3'(m);
        v.efill    = f;
        v.ed       = d;
        v.tag      = tag;
        vecs.push_back(v);
    endfunction

    task automatic check_outputs(input string tag, input logic ev, input frame_t ef,
                                 input int efill, input logic ed);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, " fill"}, 32'(bus.fill), 32'(efill));
        check({tag, " drop"}, 32'(bus.drop), 32'(ed));
        if (ev) begin
            check({tag, " total"}, 32'(bus.out_total), 32'(ef.total));
            check({tag, " max"}, 32'(bus.out_max), 32'(ef.max));
        end
    endtask

    // Reference model state for the random phase.
    frame_t     mq[$];
    int         mcnt;
    int         macc;
    int         mmx;
    logic       mdrop;

    initial begin
        int     fe;
        int     pops;
        int     phase_rdy;
        logic   iv, rdy, mpop, done;
        int     s;
        frame_t fr;
        frame_t hd;

        // Frame 1,2,3,4 with ready high.
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, "t1 s1");
        add(0, 1, 2, 1, 0, 0, 0, 0, 0, "t1 s2");
        add(0, 1, 3, 1, 0, 0, 0, 0, 0, "t1 s3");
        add(0, 1, 4, 1, 1, 10, 4, 1, 0, "t1 s4");
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "t1 pop");
        // Frame of 7s with idle gaps.
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, "t2 s1");
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, "t2 s2");
        add(0, 0, 3, 1, 0, 0, 0, 0, 0, "t2 gap");
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, "t2 s3");
        add(0, 0, 5, 1, 0, 0, 0, 0, 0, "t2 gap");
        add(0, 0, 6, 1, 0, 0, 0, 0, 0, "t2 gap");
        add(0, 1, 7, 1, 1, 28, 7, 1, 0, "t2 s4");
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "t2 pop");
        // Five frames of 1s with ready low: fifth is dropped.
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) begin
                fe = (k == 3) ? ((f < 4) ? f + 1 : 4) : f;
                add(0, 1, 1, 0, fe > 0, 4, 1, fe, (f == 4) && (k == 3), "t3 fill");
            end
        end
        add(0, 0, 0, 1, 1, 4, 1, 3, 1, "t3 drain");
        add(0, 0, 0, 1, 1, 4, 1, 2, 1, "t3 drain");
        add(0, 0, 0, 1, 1, 4, 1, 1, 1, "t3 drain");
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, "t3 drain");
        // Two frames queued and a partial third, then async reset.
        for (int k = 0; k < 4; k++) add(0, 1, 2, 0, k == 3, 8, 2, (k == 3) ? 1 : 0, 1, "t5 q1");
        for (int k = 0; k < 4; k++) add(0, 1, 3, 0, 1, 8, 2, (k == 3) ? 2 : 1, 1, "t5 q2");
        add(0, 1, 3, 0, 1, 8, 2, 2, 1, "t5 part");
        add(0, 1, 3, 0, 1, 8, 2, 2, 1, "t5 part");
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "t5 reset");
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, "t5 s1");
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, "t5 s2");
        add(0, 1, 2, 1, 0, 0, 0, 0, 0, "t5 s3");
        add(0, 1, 6, 1, 1, 13, 6, 1, 0, "t5 s4");
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "t5 pop");
        // Fill with frames 4/1..16/4, then complete a fifth while popping.
        for (int kf = 1; kf <= 4; kf++) begin
            for (int k = 0; k < 4; k++) begin
                fe = (k == 3) ? kf : kf - 1;
                add(0, 1, kf, 0, fe > 0, 4, 1, fe, 0, "t4 fill");
            end
        end
        add(0, 1, 5, 0, 1, 4, 1, 4, 0, "t4 s1");
        add(0, 1, 5, 0, 1, 4, 1, 4, 0, "t4 s2");
        add(0, 1, 5, 0, 1, 4, 1, 4, 0, "t4 s3");
        add(0, 1, 5, 1, 1, 8, 2, 4, 0, "t4 push+pop");
        add(0, 0, 0, 1, 1, 12, 3, 3, 0, "t4 drain");
        add(0, 0, 0, 1, 1, 16, 4, 2, 0, "t4 drain");
        add(0, 0, 0, 1, 1, 20, 5, 1, 0, "t4 drain");
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "t4 drain");

        // Reset state.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fr = '0;
        check_outputs("reset", 1'b0, fr, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) begin
                rst = 1'b1;
                #1;
                check_outputs(vecs[i].tag, vecs[i].ev, vecs[i].ef, vecs[i].efill, vecs[i].ed);
                rst = 1'b0;
            end else begin
                bus.in_valid  = vecs[i].iv;
                bus.in_sum    = vecs[i].s;
                bus.out_ready = vecs[i].rdy;
                @(posedge clk);
                #1;
                check_outputs(vecs[i].tag, vecs[i].ev, vecs[i].ef, vecs[i].efill, vecs[i].ed);
            end
            $display("vec %0d %s: valid=%0b total=%0d max=%0d fill=%0d drop=%0b",
                     i, vecs[i].tag, bus.out_valid, bus.out_total, bus.out_max,
                     bus.fill, bus.drop);
        end

        // Randomised run against the reference model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mq.delete();
        mcnt  = 0;
        macc  = 0;
        mmx   = 0;
        mdrop = 1'b0;
        pops  = 0;
        for (int c = 0; c < 10000; c++) begin
            phase_rdy = ((c / 500) % 2 == 0) ? 10 : 70;
            iv  = ($urandom_range(0, 3) != 0);
            s   = int'($urandom_range(0, 7));
            rdy = (int'($urandom_range(0, 99)) < phase_rdy);
            bus.in_valid  = iv;
            bus.in_sum    = 3'(s);
            bus.out_ready = rdy;

            mpop = (mq.size() > 0) && rdy;
            done = iv && (mcnt == N - 1);
            if (mpop) begin
                hd = mq.pop_front();
                pops++;
                $display("rand pop %0d: total=%0d max=%0d", pops, hd.total, hd.max);
            end
            if (iv) begin
                if (done) begin
                    fr.total = 8'(macc + s);
                    fr.max   = 3'((s > mmx) ? s : mmx);
                    if (mq.size() < DEPTH) mq.push_back(fr);
                    else mdrop = 1'b1;
                    mcnt = 0;
                    macc = 0;
                    mmx  = 0;
                end else begin
                    mcnt++;
                    macc += s;
                    if (s > mmx) mmx = s;
                end
            end

            @(posedge clk);
            #1;
            hd = (mq.size() > 0) ? mq[0] : '0;
            check_outputs("rand", mq.size() > 0, hd, mq.size(), mdrop);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_frame_packer.md
# sum_frame_packer

Downstream consumer of the registered 3-bit adder result (`c`, range 0–7). Samples the sum stream under a qualifying valid and accumulates SAMPLES_PER_FRAME samples into one frame record {total, max}. Queues completed frames in a small FIFO and presents them on a valid/ready output for the testbench/DPI side. Drops frames when the queue is full and flags the loss stickily.

## Interface
Parameters:
- `SAMPLES_PER_FRAME`, 4: valid samples per frame; must be ≥2.
- `FIFO_DEPTH`, 4: frame queue entries; must be a power of two, ≥2.
- `ACC_W`, 8: total width; must be ≥ 3+$clog2(SAMPLES_PER_FRAME).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_sum` is a sample this cycle.
- `in_sum` in 3: adder result, unsigned 0–7.
- `out_valid` out 1: FIFO head holds a frame.
- `out_ready` in 1: consumer accepts the head.
- `out_total` out ACC_W: sum of the frame's samples.
- `out_max` out 3: largest sample in the frame.
- `drop` out 1: sticky; set when a completed frame was discarded.
- `fill` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Sample counter `cnt` runs 0..SAMPLES_PER_FRAME-1. A sample is taken when `in_valid`=1.
- On a sample with `cnt`<N-1:
  - `acc` <= `acc` + `in_sum`, zero-extended to ACC_W.
  - `mx` <= max(`mx`, `in_sum`).
  - `cnt`++.
- On a sample with `cnt`=N-1:
  - The frame completes with total = `acc`+`in_sum` and max = max(`mx`, `in_sum`), both including the current sample.
  - The frame is pushed to the FIFO.
  - `acc`, `mx` and `cnt` return to 0, so a new frame starts with no gap.
- Cycles with `in_valid`=0 hold all state; gaps inside a frame are allowed.
- Push acceptance:
  - Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the frame is discarded, FIFO contents are unchanged, and `drop` <= 1.
  - `drop` clears only on reset.
- Pop happens when `out_valid` && `out_ready`. `out_ready` with an empty FIFO has no effect.
- Simultaneous push and pop: occupancy is unchanged and ordering is preserved (FIFO order).
- Arithmetic never overflows with legal parameters. Largest total is 7·N, which is 28 at the defaults.
- Outputs while `out_valid`=0: `out_total` and `out_max` are don't-care. The bench must not check them.

## Timing
- Reset values: `out_valid`=0, `drop`=0, `fill`=0, `acc`=0, `mx`=0, `cnt`=0, FIFO pointers=0.
- Reset mid-frame discards the partial frame and all queued frames, asynchronously.
- Latency from the Nth sample edge to `out_valid`=1 is one cycle, when the FIFO was empty.
- `out_total`/`out_max` are driven from FIFO storage, not combinationally from `in_sum`.
- `out_valid` and head data stay stable until a pop; the head never changes while `out_valid` && !`out_ready`.
- `fill` updates on the same edge as the push/pop that changes it.
- Throughput: one frame per N valid cycles in, one frame per cycle out.

## Structure
- Package `sum_pkg`:
  - `frame_t` packed struct {logic [ACC_W-1:0] total; logic [2:0] max;}, with ACC_W as a package constant default 8.
  - `SUM_W`=3 constant, shared with the adder stage.
- Sub-module `sync_fifo`:
  - Parameterised on element type/width and depth.
  - Ports: push, pop, wdata, rdata, full, empty, fill.
  - Pointer MSB scheme for full/empty.
  - Async active-high reset on `rst`.
- Top contains the counter/accumulator datapath and the drop logic.

## Test plan
- Reset, then samples 1,2,3,4 back-to-back with `out_ready`=1 → one cycle after the 4th sample, `out_valid`=1 with total=10, max=4; pops next cycle; `fill` returns to 0.
- Samples 7,7,7,7 with idle gaps of 0–3 cycles between them → total=28, max=7; no frame emitted before the 4th valid sample.
- `out_ready`=0, 5 frames of 1,1,1,1 → `fill`=4; 5th frame dropped; `drop`=1; four entries of total=4, max=1 drained in order once ready rises.
- FIFO full and 5th frame completes in the same cycle as a pop → no drop; `fill` stays 4; head advances.
- Assert `rst` after 2 samples of a frame and with 2 frames queued → `out_valid`=0, `fill`=0, `drop`=0 immediately. A new frame 0,5,2,6 then yields total=13, max=6.
- Random `in_valid`/`out_ready` over 10k cycles against a reference model: all non-dropped frames match, and `drop` is set iff a push met full without a pop.
